// File: rtl/acc_rmw_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acc_pkg
// Brief    : Shared types and default widths for the accumulator RMW
//            controller and its accumulator bank.
// Revision : 1.0 - initial release
// ============================================================================
package acc_pkg;

    // Default widths shared with the accumulator bank RAM
    localparam int ACC_ADDR_WIDTH = 6;
    localparam int ACC_DATA_WIDTH = 16;

    // Controller operating mode
    typedef enum logic [1:0] {
        ACC        = 2'd0,
        DRAIN_WAIT = 2'd1,
        DRAIN      = 2'd2
    } acc_state_e;

    // One in-flight update; fields are sized by the package defaults, so a
    // width override on the controller must be mirrored here.
    typedef struct packed {
        logic [ACC_ADDR_WIDTH-1:0] addr;
        logic [ACC_DATA_WIDTH-1:0] data;
        logic                      clear;
    } acc_req_t;

endpackage : acc_pkg
`default_nettype wire

// File: rtl/acc_rmw_fwd.sv
`default_nettype none
// ============================================================================
// Module   : acc_rmw_fwd
// Brief    : Read-modify-write datapath: picks the S1 operand (RAM read or
//            forwarded last write), adds or overwrites, and keeps the
//            one-entry forward register of the most recent RAM write.
// Revision : 1.0 - initial release
// ============================================================================
module acc_rmw_fwd
    import acc_pkg::*;
#(
    parameter int ADDR_WIDTH = ACC_ADDR_WIDTH,
    parameter int DATA_WIDTH = ACC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_s1_addr,
    input  logic [DATA_WIDTH-1:0] i_s1_data,
    input  logic                  i_s1_clear,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_sum
);

    logic                  r_fwd_valid;
    logic [ADDR_WIDTH-1:0] r_fwd_addr;
    logic [DATA_WIDTH-1:0] r_fwd_data;
    logic                  w_fwd_hit;
    logic [DATA_WIDTH-1:0] w_operand;

    // A read issued in the same cycle as a write returns the stale word, so
    // the write of the previous cycle overrides the RAM data on an address match.
    assign w_fwd_hit = r_fwd_valid && (r_fwd_addr == i_s1_addr);
    assign w_operand = w_fwd_hit ? r_fwd_data : i_ram_rdata;
    assign o_sum     = i_s1_clear ? i_s1_data : (w_operand + i_s1_data);

    // Capture every RAM write; valid lasts exactly the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
        end else begin
            r_fwd_valid <= i_wr_en;
            if (i_wr_en) begin
                r_fwd_addr <= i_waddr;
                r_fwd_data <= i_wdata;
            end
        end
    end

endmodule : acc_rmw_fwd
`default_nettype wire

// File: rtl/acc_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : acc_rmw_ctrl
// Brief    : Read-modify-write sequencer for one accumulator bank on a
//            pseudo dual-port RAM with 1-cycle registered read. Accumulates
//            one update per cycle and drains the bank with valid/ready.
//            Build option ACC_RMW_ZERO_ON_DRAIN_EN: every drain handshake
//            also writes zero to the drained word.
// Revision : 1.0 - initial release
// ============================================================================
module acc_rmw_ctrl
    import acc_pkg::*;
#(
    parameter int ADDR_WIDTH = ACC_ADDR_WIDTH,
    parameter int DATA_WIDTH = ACC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_clear,
    input  logic                  drain_start,
    output logic                  drain_busy,
    output logic                  drain_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ram_wr_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    acc_state_e            r_state;
    acc_req_t              r_s1;
    logic                  r_s1_valid;
    logic                  r_drain_busy;
    logic                  r_drain_done;
    logic                  r_out_valid;
    logic [ADDR_WIDTH-1:0] r_out_addr;

    logic                  w_accept;
    logic                  w_drain_enter;
    logic                  w_drain_hs;
    logic                  w_drain_last;
    logic [DATA_WIDTH-1:0] w_sum;

    // Drain request takes priority over a same-cycle update
    assign in_ready      = !rst && (r_state == ACC) && !drain_start;
    assign w_accept      = in_valid && in_ready;
    assign w_drain_enter = (r_state == DRAIN_WAIT) && !r_s1_valid;
    assign w_drain_hs    = (r_state == DRAIN) && r_out_valid && out_ready;
    assign w_drain_last  = w_drain_hs && (&r_out_addr);

    assign drain_busy = r_drain_busy;
    assign drain_done = r_drain_done;
    assign out_valid  = r_out_valid;
    assign out_addr   = r_out_addr;
    assign out_data   = ram_rdata;
    assign ram_we     = ram_wr_en;

    acc_rmw_fwd #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fwd (
        .clk         (clk),
        .rst         (rst),
        .i_s1_addr   (r_s1.addr),
        .i_s1_data   (r_s1.data),
        .i_s1_clear  (r_s1.clear),
        .i_ram_rdata (ram_rdata),
        .i_wr_en     (ram_wr_en),
        .i_waddr     (ram_waddr),
        .i_wdata     (ram_wdata),
        .o_sum       (w_sum)
    );

    // Read port: update lookups, first drain word, and the next drain word
    // on each handshake; no read while stalled so the RAM output holds.
    always_comb begin
        ram_rd_en = 1'b0;
        ram_raddr = in_addr;
        if (!rst) begin
            if (w_accept) begin
                ram_rd_en = 1'b1;
            end else if (w_drain_enter) begin
                ram_rd_en = 1'b1;
                ram_raddr = '0;
            end else if (w_drain_hs && !w_drain_last) begin
                ram_rd_en = 1'b1;
                ram_raddr = r_out_addr + 1'b1;
            end
        end
    end

    // Write port: S1 commit, or zeroing of the drained word when enabled.
    // Gated by reset so an abandoned operation never lands in the RAM.
    always_comb begin
        ram_wr_en = 1'b0;
        ram_waddr = r_s1.addr;
        ram_wdata = w_sum;
        if (!rst) begin
            if (r_s1_valid) begin
                ram_wr_en = 1'b1;
            end
`ifdef ACC_RMW_ZERO_ON_DRAIN_EN
            else if (w_drain_hs) begin
                ram_wr_en = 1'b1;
                ram_waddr = r_out_addr;
                ram_wdata = '0;
            end
`endif
        end
    end

    // Mode FSM, S1 pipeline register and registered drain outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ACC;
            r_s1         <= '0;
            r_s1_valid   <= 1'b0;
            r_drain_busy <= 1'b0;
            r_drain_done <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_addr   <= '0;
        end else begin
            r_s1_valid   <= w_accept;
            r_drain_done <= 1'b0;
            if (w_accept) begin
                r_s1.addr  <= in_addr;
                r_s1.data  <= in_data;
                r_s1.clear <= in_clear;
            end
            case (r_state)
                ACC: begin
                    if (drain_start) begin
                        r_state      <= DRAIN_WAIT;
                        r_drain_busy <= 1'b1;
                    end
                end
                DRAIN_WAIT: begin
                    if (!r_s1_valid) begin
                        r_state     <= DRAIN;
                        r_out_valid <= 1'b1;
                        r_out_addr  <= '0;
                    end
                end
                DRAIN: begin
                    if (w_drain_hs) begin
                        if (w_drain_last) begin
                            r_state      <= ACC;
                            r_out_valid  <= 1'b0;
                            r_drain_busy <= 1'b0;
                            r_drain_done <= 1'b1;
                        end else begin
                            r_out_addr <= r_out_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ACC;
                end
            endcase
        end
    end

endmodule : acc_rmw_ctrl
`default_nettype wire
